// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES request arbiter
package aes_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} aes_state_e;

    localparam int AES_BLK_W    = 128;
    localparam int AES_CORE_LAT = 21;
    localparam int AES_TIMEOUT  = 32;

endpackage

// File: rtl/aes_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             any
);

    int idx;

    always_comb begin
        gnt = '0;
        idx = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (gnt == '0 && req[idx[PW-1:0]]) gnt[idx[PW-1:0]] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES core among N_REQ requesters with round-robin grant and RUN timeout
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = AES_TIMEOUT,
    parameter int CW      = 6
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [AES_BLK_W*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [AES_BLK_W-1:0]       rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       busy_o,
    output logic                       aes_start_o,
    output logic [AES_BLK_W-1:0]       aes_plain_o,
    input  logic                       aes_done_i,
    input  logic [AES_BLK_W-1:0]       aes_cipher_i
);

    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    aes_state_e            state, state_n;
    logic [PW-1:0]         rr_ptr, gnt_idx;
    logic [CW-1:0]         cnt;
    logic [N_REQ-1:0]      pick;
    logic                  any_req;
    logic [AES_BLK_W-1:0]  pick_data;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (pick),
        .any (any_req)
    );

    always_comb begin
        pick_data = '0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick[k]) pick_data = req_data_i[k*AES_BLK_W +: AES_BLK_W];
            if (gnt_o[k]) gnt_idx = PW'(k);
        end
    end

    // done has priority over the timeout when both land on the last RUN cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any_req ? LOAD : IDLE;
            LOAD:    state_n = RUN;
            RUN:     state_n = (aes_done_i || cnt == TO_LAST) ? RESP : RUN;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            gnt_o       <= '0;
            aes_plain_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            cnt         <= '0;
            rr_ptr      <= PW'(N_REQ - 1);
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                gnt_o       <= pick;
                aes_plain_o <= pick_data;
            end
            if (state == LOAD) cnt <= '0;
            if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (aes_done_i) begin
                    rsp_data_o <= aes_cipher_i;
                    rsp_err_o  <= 1'b0;
                end else if (cnt == TO_LAST) begin
                    rsp_data_o <= '0;
                    rsp_err_o  <= 1'b1;
                end
            end
            if (state == RESP) begin
                rr_ptr <= gnt_idx;
                gnt_o  <= '0;
            end
        end
    end

    assign aes_start_o = state == LOAD;
    assign rsp_valid_o = state == RESP ? gnt_o : '0;
    assign busy_o      = state != IDLE;

endmodule
